// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU result latch stage.
// Function codes, FSM states and the condition-flag bundle live here.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int TMR_W     = $clog2(256);

  typedef enum logic [2:0] {
    FN_ADD = 3'd0,
    FN_INC = 3'd1,
    FN_AND = 3'd2,
    FN_OR  = 3'd3,
    FN_XOR = 3'd4,
    FN_NOT = 3'd5,
    FN_SHL = 3'd6,
    FN_CLR = 3'd7
  } alu_fn_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic zero;
    logic sign;
    logic carry;
  } cond_flags_t;

  function automatic logic is_arith(input alu_fn_t fn);
    return (fn == FN_ADD) || (fn == FN_INC);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that marks when the adder/logic outputs have settled.
// zero is asserted once the count has run out; it stops at zero.
module settle_timer
  import alu_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                 cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alu_result_latch.sv
// Captures the ALU result after a programmable settle interval, updates Z/S/C
// and presents the result under a valid/ack handshake.
module alu_result_latch
  import alu_pkg::*;
#(
  parameter int WIDTH         = ALU_WIDTH,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_fn,
  input  logic [WIDTH-1:0] sum_bits,
  input  logic             carry_out,
  input  logic [WIDTH-1:0] logic_bits,
  input  logic             result_ack,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_sign,
  output logic             flag_carry,
  output logic             cond_load
);

  // Counter is loaded with N-1 so capture lands exactly N edges after accept.
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

  state_t           state;
  alu_fn_t          fn_q;
  cond_flags_t      flags;
  logic [WIDTH-1:0] nxt_result;
  logic             tmr_zero;
  logic             accept;

  assign accept = (state == ST_IDLE) && start;

  settle_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .dec      (state == ST_SETTLE),
    .load_val (SETTLE_LOAD),
    .zero     (tmr_zero)
  );

  always_comb begin
    nxt_result = logic_bits;
    case (fn_q)
      FN_ADD, FN_INC: nxt_result = sum_bits;
      FN_CLR:         nxt_result = '0;
      default:        nxt_result = logic_bits;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      fn_q         <= FN_ADD;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      flags        <= '0;
      cond_load    <= 1'b0;
    end else begin
      cond_load <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            fn_q  <= alu_fn_t'(alu_fn);
            busy  <= 1'b1;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            result       <= nxt_result;
            flags.zero   <= (nxt_result == '0);
            flags.sign   <= nxt_result[WIDTH-1];
            // Logic ops leave the arithmetic carry untouched.
            if (is_arith(fn_q)) flags.carry <= carry_out;
            cond_load    <= 1'b1;
            result_valid <= 1'b1;
            state        <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign flag_zero  = flags.zero;
  assign flag_sign  = flags.sign;
  assign flag_carry = flags.carry;

endmodule

// File: tb/tb_alu_result_latch.sv
// Scoreboard bench for alu_result_latch: stimulus pushes expected captures,
// per-instance monitors pop and compare on each result_valid rise.
module tb_alu_result_latch;
  import alu_pkg::*;

  typedef struct {
    logic [7:0] res;
    logic       z, s, c;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, start1 = 1'b0;
  logic [2:0] alu_fn = 3'd0;
  logic [7:0] sum_bits = 8'h00, logic_bits = 8'h00;
  logic       carry_out = 1'b0;
  logic       result_ack = 1'b0, ack1 = 1'b0;

  logic       busy, result_valid, flag_zero, flag_sign, flag_carry, cond_load;
  logic [7:0] result;
  logic       busy1, valid1, zero1, sign1, carry1, cload1;
  logic [7:0] result1;

  int   checks = 0, errors = 0, cyc = 0;
  exp_t q4[$], q1[$];

  alu_result_latch #(.WIDTH(8), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_fn(alu_fn),
    .sum_bits(sum_bits), .carry_out(carry_out), .logic_bits(logic_bits),
    .result_ack(result_ack), .busy(busy), .result_valid(result_valid),
    .result(result), .flag_zero(flag_zero), .flag_sign(flag_sign),
    .flag_carry(flag_carry), .cond_load(cond_load)
  );

  alu_result_latch #(.WIDTH(8), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .alu_fn(alu_fn),
    .sum_bits(sum_bits), .carry_out(carry_out), .logic_bits(logic_bits),
    .result_ack(ack1), .busy(busy1), .result_valid(valid1),
    .result(result1), .flag_zero(zero1), .flag_sign(sign1),
    .flag_carry(carry1), .cond_load(cload1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitors: a capture must match the head of the queue, including the edge
  // it appeared on; cond_load outside a capture is an error.
  logic pv4 = 1'b0, pv1 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (result_valid && !pv4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL cap4_unexpected: got res=%h at cycle %0d, required no capture", result, cyc);
      end else begin
        e = q4.pop_front();
        if (result !== e.res || flag_zero !== e.z || flag_sign !== e.s ||
            flag_carry !== e.c || cond_load !== 1'b1 || cyc != e.cyc) begin
          errors++;
          $display("FAIL cap4: got res=%h z%b s%b c%b cl%b cyc%0d, required res=%h z%b s%b c%b cl1 cyc%0d",
                   result, flag_zero, flag_sign, flag_carry, cond_load, cyc,
                   e.res, e.z, e.s, e.c, e.cyc);
        end
      end
    end else if (cond_load) begin
      checks++; errors++;
      $display("FAIL cond_load4_spurious: got 1 at cycle %0d, required 0", cyc);
    end
    pv4 = result_valid;
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid1 && !pv1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL cap1_unexpected: got res=%h at cycle %0d, required no capture", result1, cyc);
      end else begin
        e = q1.pop_front();
        if (result1 !== e.res || zero1 !== e.z || sign1 !== e.s ||
            carry1 !== e.c || cload1 !== 1'b1 || cyc != e.cyc) begin
          errors++;
          $display("FAIL cap1: got res=%h z%b s%b c%b cl%b cyc%0d, required res=%h z%b s%b c%b cl1 cyc%0d",
                   result1, zero1, sign1, carry1, cload1, cyc,
                   e.res, e.z, e.s, e.c, e.cyc);
        end
      end
    end else if (cload1) begin
      checks++; errors++;
      $display("FAIL cond_load1_spurious: got 1 at cycle %0d, required 0", cyc);
    end
    pv1 = valid1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] r, input logic z, input logic s,
                              input logic c, input int at);
    exp_t e;
    e.res = r; e.z = z; e.s = s; e.c = c; e.cyc = at;
    return e;
  endfunction

  // Called at a negedge; start is taken on the next posedge (cyc+1).
  task automatic issue(input alu_fn_t fn, input logic [7:0] r, input logic z,
                       input logic s, input logic c);
    alu_fn = fn;
    start  = 1'b1;
    q4.push_back(mk(r, z, s, c, cyc + 1 + 4));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_and_ack(input int hold, input string name);
    logic [7:0] r;
    int n;
    n = 0;
    while (!result_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid_seen"}, 32'(result_valid), 32'd1);
    r = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_stable"}, {23'd0, result_valid, r}, {23'd0, 1'b1, result});
    end
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check({name, "_after_ack"}, {22'd0, busy, result_valid, result}, {22'd0, 2'b00, r});
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {18'd0, busy, result_valid, result, flag_zero, flag_sign, flag_carry, cond_load},
          32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: ADD 00 with carry -> zero, carry
    sum_bits = 8'h00; carry_out = 1'b1;
    issue(FN_ADD, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_and_ack(0, "t1");

    // 2: AND 80 keeps carry; held for 5 cycles before ack
    logic_bits = 8'h80; carry_out = 1'b0;
    issue(FN_AND, 8'h80, 1'b0, 1'b1, 1'b1);
    wait_and_ack(5, "t2");

    // 3: sum_bits churns during SETTLE; only the capture-edge value counts
    alu_fn = 3'(FN_ADD); start = 1'b1; sum_bits = 8'h11; carry_out = 1'b1;
    q4.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0, cyc + 1 + 4));
    @(negedge clk); start = 1'b0; sum_bits = 8'h22;
    @(negedge clk); start = 1'b1; sum_bits = 8'hF0;
    @(negedge clk); start = 1'b0; sum_bits = 8'h00;
    @(negedge clk); sum_bits = 8'h3C; carry_out = 1'b0;
    @(negedge clk); sum_bits = 8'hAA; carry_out = 1'b1;
    check("t3_valid", 32'(result_valid), 32'd1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_and_ack(1, "t3");
    repeat (6) @(negedge clk);
    check("t3_no_second_op", 32'(busy), 32'd0);

    // 4: reset two edges into SETTLE aborts with no capture
    sum_bits = 8'h77; carry_out = 1'b1; alu_fn = 3'(FN_ADD); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("t4_reset_abort",
          {18'd0, busy, result_valid, result, flag_zero, flag_sign, flag_carry, cond_load},
          32'd0);
    reset = 1'b0;
    @(negedge clk);
    sum_bits = 8'h81; carry_out = 1'b1;
    issue(FN_ADD, 8'h81, 1'b0, 1'b1, 1'b1);
    wait_and_ack(0, "t4");

    // 5: CLR keeps carry from the ADD
    logic_bits = 8'h5A; sum_bits = 8'h5A; carry_out = 1'b0;
    issue(FN_CLR, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_and_ack(0, "t5");

    // 5b: SETTLE_CYCLES=1 instance captures on the first edge after accept
    sum_bits = 8'h55; carry_out = 1'b0; alu_fn = 3'(FN_ADD); start1 = 1'b1;
    q1.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0, cyc + 2));
    @(negedge clk); start1 = 1'b0;
    @(negedge clk);
    check("t5_s1_valid", 32'(valid1), 32'd1);
    ack1 = 1'b1;
    @(negedge clk); ack1 = 1'b0;
    check("t5_s1_after_ack", 32'(valid1), 32'd0);

    // 6: ack and start together; the new op is accepted one edge later
    logic_bits = 8'h0F;
    issue(FN_OR, 8'h0F, 1'b0, 1'b0, 1'b1);
    while (!result_valid && cyc < 2000) @(negedge clk);
    result_ack = 1'b1; start = 1'b1; alu_fn = 3'(FN_INC);
    sum_bits = 8'hFF; carry_out = 1'b0;
    q4.push_back(mk(8'hFF, 1'b0, 1'b1, 1'b0, cyc + 2 + 4));
    @(negedge clk); result_ack = 1'b0;
    check("t6_idle_after_ack", 32'(result_valid), 32'd0);
    @(negedge clk); start = 1'b0;
    wait_and_ack(0, "t6");

    repeat (4) @(negedge clk);
    check("queues_drained", q4.size() + q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
